lcd_receptor: RTL

- Write-only responder for the HD44780-style character LCD bus (lcd_data/lcd_en/lcd_rs/lcd_rw) driven by the calculator's display writer.
- Decodes each bus write into a command or a character and keeps a 2x16 character buffer, cursor and busy timer.
- Exposes a registered read port so a checker or mirror display can observe screen contents.
- Sits on the far end of the LCD interface: in simulation it stands in for the panel, on-chip it is a display snooper.

---
 rtl/lcd_receptor_if.sv | 11 +
 rtl/lcd_receptor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_receptor_if.sv
// HD44780-style character LCD write bus (data, enable, register select, read/write).
// The display writer drives the master side; the receptor listens on the slave side.
interface lcd_receptor_if;
    logic [7:0] lcd_data;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;

    modport master (output lcd_data, output lcd_en, output lcd_rs, output lcd_rw);
    modport slave  (input  lcd_data, input  lcd_en, input  lcd_rs, input  lcd_rw);
endinterface

// File: rtl/lcd_receptor.sv
// lcd_receptor: write-only responder for an HD44780-style 2x16 character LCD bus.
// Decodes each falling edge of lcd_en into a command or a character, keeps a
// 32-entry character buffer, a cursor, an entry mode and a busy timer, and offers
// a registered read port for a checker or mirror display.
// Optional build macro LCD_RECEPTOR_BUSY_CHECK_EN: when defined, writes arriving
// while busy or during the clear sweep are dropped and flagged on err_busy.
// Without it every write is accepted, a write aborts a running clear sweep and
// err_busy stays 0.
module lcd_receptor #(
    parameter int unsigned BUSY_CYC  = 2000,
    parameter int unsigned CLEAR_CYC = 80000   // must be >= 32 so the sweep finishes first
) (
    input  logic          clk,
    input  logic          rst_n,
    lcd_receptor_if.slave lcd,
    input  logic [4:0]    rd_addr,
    output logic [7:0]    rd_char,
    output logic [4:0]    cursor,
    output logic          busy,
    output logic          cmd_valid,
    output logic [7:0]    cmd_code,
    output logic          err_busy,
    input  logic          err_clr
);

    localparam int unsigned MAX_CYC = (CLEAR_CYC > BUSY_CYC) ? CLEAR_CYC : BUSY_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Registered copies of the bus
    logic       en_q;
    logic [7:0] data_q;
    logic       rs_q;
    logic       rw_q;

    // Core state
    state_t           state_q,    state_d;
    logic [4:0]       clr_idx_q,  clr_idx_d;
    logic [4:0]       cursor_q,   cursor_d;
    logic             inc_q,      inc_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             busy_q;
    logic             cmd_valid_q, cmd_valid_d;
    logic [7:0]       cmd_code_q,  cmd_code_d;
    logic             err_q,       err_d;
    logic [7:0]       buf_q [32];
    logic [7:0]       rd_char_q;

    // Buffer write port (single port shared by bus writes and the clear sweep)
    logic       wr_en_s;
    logic [4:0] wr_idx_s;
    logic [7:0] wr_data_s;

    logic strobe_s;
    logic wr_strobe_s;
    logic blocked_s;
    logic accept_s;

    // Strobe on the falling edge of enable; reads (rw=1) are ignored entirely
    always_comb begin
        strobe_s    = en_q & ~lcd.lcd_en;
        wr_strobe_s = strobe_s & ~rw_q;
`ifdef LCD_RECEPTOR_BUSY_CHECK_EN
        blocked_s   = wr_strobe_s & (busy_q | (state_q == ST_CLEAR));
`else
        blocked_s   = 1'b0;
`endif
        accept_s    = wr_strobe_s & ~blocked_s;
    end

    // Bus input register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            data_q <= 8'h00;
            rs_q   <= 1'b0;
            rw_q   <= 1'b0;
        end else begin
            en_q   <= lcd.lcd_en;
            data_q <= lcd.lcd_data;
            rs_q   <= lcd.lcd_rs;
            rw_q   <= lcd.lcd_rw;
        end
    end

    // Next-state logic: command decode, cursor movement, clear sweep, busy timer
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        cursor_d    = cursor_q;
        inc_d       = inc_q;
        cnt_d       = (cnt_q == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (cnt_q - {{(CNT_W-1){1'b0}}, 1'b1});
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        wr_en_s     = 1'b0;
        wr_idx_s    = 5'd0;
        wr_data_s   = 8'h20;

        if (accept_s) begin
            // An accepted write always leaves the sweep (aborting it if one was running)
            state_d = ST_IDLE;
            cnt_d   = CNT_W'(BUSY_CYC);
            if (rs_q) begin
                wr_en_s   = 1'b1;
                wr_idx_s  = cursor_q;
                wr_data_s = data_q;
                cursor_d  = inc_q ? (cursor_q + 5'd1) : (cursor_q - 5'd1);
            end else begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = data_q;
                if (data_q == 8'h01) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = 5'd0;
                    cursor_d  = 5'd0;
                    inc_d     = 1'b1;
                    cnt_d     = CNT_W'(CLEAR_CYC);
                end else if (data_q[7]) begin
                    cursor_d = {data_q[6], data_q[3:0]};
                end else if (data_q[7:1] == 7'h01) begin
                    cursor_d = 5'd0;
                end else if (data_q[7:2] == 6'h01) begin
                    inc_d = data_q[1];
                end else begin
                    cursor_d = cursor_q;   // reported only
                end
            end
        end else if (state_q == ST_CLEAR) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = clr_idx_q;
            wr_data_s = 8'h20;
            clr_idx_d = clr_idx_q + 5'd1;
            state_d   = (clr_idx_q == 5'd31) ? ST_IDLE : ST_CLEAR;
        end else begin
            state_d = state_q;
        end

        if (blocked_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clr_idx_q   <= 5'd0;
            cursor_q    <= 5'd0;
            inc_q       <= 1'b1;
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            cursor_q    <= cursor_d;
            inc_q       <= inc_d;
            cnt_q       <= cnt_d;
            busy_q      <= (cnt_d != {CNT_W{1'b0}});
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            err_q       <= err_d;
        end
    end

    // Character buffer; reset restores every cell to a space at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                buf_q[i] <= 8'h20;
            end
        end else if (wr_en_s) begin
            buf_q[wr_idx_s] <= wr_data_s;
        end
    end

    // Registered read port (read-during-write returns the old value)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_char_q <= 8'h20;
        end else begin
            rd_char_q <= buf_q[rd_addr];
        end
    end

    assign rd_char   = rd_char_q;
    assign cursor    = cursor_q;
    assign busy      = busy_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign err_busy  = err_q;

endmodule
